// File: rtl/ekf_pkg.sv
// Shared EKF stage codes, fixed-point layout and sequencer state types.
package ekf_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRD   = 3'd1;
  localparam logic [2:0] NEW   = 3'd2;
  localparam logic [2:0] UPD   = 3'd3;
  localparam logic [2:0] ASSOC = 3'd4;

  localparam int DATA_INT_BIT = 12;
  localparam int DATA_DEC_BIT = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRD,
    S_PRD_WAIT,
    S_OBS,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_PULSE,
    I_WAIT
  } iss_state_t;

endpackage

// File: rtl/ekf_stage_sequencer_if.sv
// Host command / Top stage bundle for the EKF stage sequencer.
interface ekf_stage_sequencer_if #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10
);

  logic               odo_val;
  logic               odo_rdy;
  logic [RSA_DW-1:0]  odo_vlr;
  logic [RSA_AW-1:0]  odo_alpha;
  logic               odo_noobs;

  logic               obs_val;
  logic               obs_rdy;
  logic [RSA_DW-1:0]  obs_rk;
  logic [RSA_AW-1:0]  obs_phi;
  logic [ROW_LEN-1:0] obs_lk;
  logic               obs_new;
  logic               obs_last;

  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;

  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] l_k;
  logic [RSA_DW-1:0]  vlr;
  logic [RSA_DW-1:0]  rk;
  logic [RSA_AW-1:0]  alpha;
  logic [RSA_AW-1:0]  phi;

  logic               busy;
  logic               frame_done;
  logic               drop;
  logic               err;

  modport master (
    output odo_val, odo_vlr, odo_alpha, odo_noobs,
    output obs_val, obs_rk, obs_phi, obs_lk,
    output obs_new, obs_last, stage_rdy,
    input  odo_rdy, obs_rdy, stage_val,
    input  landmark_num, l_k, vlr, rk, alpha, phi,
    input  busy, frame_done, drop, err
  );

  modport slave (
    input  odo_val, odo_vlr, odo_alpha, odo_noobs,
    input  obs_val, obs_rk, obs_phi, obs_lk,
    input  obs_new, obs_last, stage_rdy,
    output odo_rdy, obs_rdy, stage_val,
    output landmark_num, l_k, vlr, rk, alpha, phi,
    output busy, frame_done, drop, err
  );

endinterface

// File: rtl/ekf_stage_issuer.sv
// Issue-pulse / completion-wait engine; watchdog under EKF_SEQ_TIMEOUT_EN.
module ekf_stage_issuer
  import ekf_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [2:0] code,
  input  logic [2:0] stage_rdy,
  output logic [2:0] stage_val,
  output logic       pulse_end,
  output logic       done,
  output logic       timeout
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  if (PULSE_LEN < 1) begin : g_bad_pulse
    $error("PULSE_LEN must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("TIMEOUT must be >= 1");
  end

  iss_state_t     st_q, st_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [2:0]     code_q;

  assign stage_val = (st_q == I_PULSE) ? code_q : IDLE;
  assign pulse_end = (st_q == I_PULSE)
                  && (pcnt_q == PW'(PULSE_LEN - 1));
  // stage_rdy is only looked at once the pulse is over
  assign done      = (st_q == I_WAIT) && (stage_rdy == code_q);

`ifdef EKF_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  always_ff @(posedge clk) begin
    if (sys_rst || st_q != I_WAIT) tcnt_q <= '0;
    else                           tcnt_q <= tcnt_q + TW'(1);
  end

  assign timeout = (st_q == I_WAIT) && !done
                && (tcnt_q == TW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    pcnt_d = pcnt_q;
    unique case (st_q)
      I_IDLE: begin
        if (start) begin
          st_d   = I_PULSE;
          pcnt_d = '0;
        end
      end
      I_PULSE: begin
        if (pulse_end) st_d   = I_WAIT;
        else           pcnt_d = pcnt_q + PW'(1);
      end
      I_WAIT: begin
        if (done || timeout) st_d = I_IDLE;
      end
      default: st_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      st_q   <= I_IDLE;
      pcnt_q <= '0;
      code_q <= IDLE;
    end else begin
      st_q   <= st_d;
      pcnt_q <= pcnt_d;
      if (st_q == I_IDLE && start) code_q <= code;
    end
  end

endmodule

// File: rtl/ekf_stage_sequencer.sv
// Frame sequencer: odometry -> PRD, observations -> NEW/UPD, landmark count.
// Optional watchdog: define EKF_SEQ_TIMEOUT_EN.
module ekf_stage_sequencer
  import ekf_pkg::*;
#(
  parameter int RSA_DW    = 32,
  parameter int RSA_AW    = 17,
  parameter int ROW_LEN   = 10,
  parameter int MAX_LM    = 64,
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  ekf_stage_sequencer_if.slave bus
);

  if (MAX_LM > (1 << ROW_LEN) - 1) begin : g_bad_cap
    $error("MAX_LM exceeds landmark index range");
  end

  seq_state_t         st_q, st_d;
  logic               odo_hs, obs_hs, full;
  logic               iss_start, iss_end;
  logic               iss_done, iss_to;
  logic [2:0]         iss_code;
  logic               drop_ev;
  logic               noobs_q, last_q, new_q, drop_q;
  logic [RSA_DW-1:0]  vlr_q, rk_q;
  logic [RSA_AW-1:0]  alpha_q, phi_q;
  logic [ROW_LEN-1:0] lk_q, lm_q;

  assign odo_hs = bus.odo_val && (st_q == S_IDLE);
  assign obs_hs = bus.obs_val && (st_q == S_OBS);
  assign full   = lm_q >= ROW_LEN'(MAX_LM);

  ekf_stage_issuer #(
    .PULSE_LEN (PULSE_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_issuer (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (iss_start),
    .code      (iss_code),
    .stage_rdy (bus.stage_rdy),
    .stage_val (bus.stage_val),
    .pulse_end (iss_end),
    .done      (iss_done),
    .timeout   (iss_to)
  );

  always_comb begin
    st_d      = st_q;
    iss_start = 1'b0;
    iss_code  = IDLE;
    drop_ev   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (odo_hs) begin
          iss_start = 1'b1;
          iss_code  = PRD;
          st_d      = S_PRD;
        end
      end
      S_PRD: begin
        if (iss_end) st_d = S_PRD_WAIT;
      end
      S_PRD_WAIT: begin
        if (iss_done)    st_d = noobs_q ? S_DONE : S_OBS;
        else if (iss_to) st_d = S_IDLE;
      end
      S_OBS: begin
        if (obs_hs) begin
          if (bus.obs_new && full) begin
            drop_ev = 1'b1;
            st_d    = bus.obs_last ? S_DONE : S_OBS;
          end else begin
            iss_start = 1'b1;
            iss_code  = bus.obs_new ? NEW : UPD;
            st_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (iss_end) st_d = S_WAIT;
      end
      S_WAIT: begin
        if (iss_done)    st_d = last_q ? S_DONE : S_OBS;
        else if (iss_to) st_d = S_IDLE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) st_q <= S_IDLE;
    else         st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      vlr_q   <= '0;
      alpha_q <= '0;
      rk_q    <= '0;
      phi_q   <= '0;
      lk_q    <= '0;
      lm_q    <= '0;
      noobs_q <= 1'b0;
      last_q  <= 1'b0;
      new_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_ev;
      if (odo_hs) begin
        vlr_q   <= bus.odo_vlr;
        alpha_q <= bus.odo_alpha;
        noobs_q <= bus.odo_noobs;
      end
      if (obs_hs) begin
        last_q <= bus.obs_last;
        // a dropped observation leaves the presented operands alone
        if (!drop_ev) begin
          rk_q  <= bus.obs_rk;
          phi_q <= bus.obs_phi;
          new_q <= bus.obs_new;
          lk_q  <= bus.obs_new ? lm_q : bus.obs_lk;
        end
      end
      if (st_q == S_WAIT && iss_done && new_q)
        lm_q <= lm_q + ROW_LEN'(1);
    end
  end

`ifdef EKF_SEQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (sys_rst)     err_q <= 1'b0;
    else if (odo_hs) err_q <= 1'b0;
    else if (iss_to) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.odo_rdy      = (st_q == S_IDLE);
  assign bus.obs_rdy      = (st_q == S_OBS);
  assign bus.busy         = (st_q != S_IDLE);
  assign bus.frame_done   = (st_q == S_DONE);
  assign bus.drop         = drop_q;
  assign bus.landmark_num = lm_q;
  assign bus.l_k          = lk_q;
  assign bus.vlr          = vlr_q;
  assign bus.alpha        = alpha_q;
  assign bus.rk           = rk_q;
  assign bus.phi          = phi_q;

endmodule
